// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
package seg_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned AN_W       = 4;

    // Slot order: SLOT0 shows the thousands digit on an[3], SLOT3 the units on an[0]
    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_e;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [AN_W-1:0]  AN_OFF    = 4'b1111;

    // Digit pattern table, element n holds the pattern for decimal n
    localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    // Coherent per-frame copy of the display inputs
    typedef struct packed {
        logic [DIGIT_W-1:0] d1;
        logic [DIGIT_W-1:0] d2;
        logic [DIGIT_W-1:0] d3;
        logic [DIGIT_W-1:0] d4;
        logic               blank_lz;
    } snapshot_t;

    // Active-low anode enable for a slot
    function automatic logic [AN_W-1:0] slot_anode(input slot_e s);
        logic [AN_W-1:0] a;
        case (s)
            SLOT0: a = 4'b0111;
            SLOT1: a = 4'b1011;
            SLOT2: a = 4'b1101;
            SLOT3: a = 4'b1110;
        endcase
        return a;
    endfunction

    // Scan order successor
    function automatic slot_e slot_next(input slot_e s);
        slot_e n;
        case (s)
            SLOT0: n = SLOT1;
            SLOT1: n = SLOT2;
            SLOT2: n = SLOT3;
            SLOT3: n = SLOT0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low 7-segment pattern; non-BCD codes show a dash.
module seg7_decoder
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   seg_c
);

    // Table lookup for 0-9, dash for everything else
    always_comb begin
        seg_c = SEG_DASH;
        case (digit)
            4'd0: seg_c = SEG_TABLE[0];
            4'd1: seg_c = SEG_TABLE[1];
            4'd2: seg_c = SEG_TABLE[2];
            4'd3: seg_c = SEG_TABLE[3];
            4'd4: seg_c = SEG_TABLE[4];
            4'd5: seg_c = SEG_TABLE[5];
            4'd6: seg_c = SEG_TABLE[6];
            4'd7: seg_c = SEG_TABLE[7];
            4'd8: seg_c = SEG_TABLE[8];
            4'd9: seg_c = SEG_TABLE[9];
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-multiplexes four BCD digits onto a shared 4-anode 7-segment display,
// taking a coherent snapshot of the digits once per frame.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 17
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] digit1,
    input  logic [DIGIT_W-1:0] digit2,
    input  logic [DIGIT_W-1:0] digit3,
    input  logic [DIGIT_W-1:0] digit4,
    input  logic               blank_lz,
    output logic [AN_W-1:0]    an,
    output logic [SEG_W-1:0]   seg,
    output logic               frame_tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    slot_e            slot_q, slot_d;
    logic             run_q, run_d;
    snapshot_t        shadow_q, shadow_d;
    logic [AN_W-1:0]  an_q, an_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             frame_tick_q, frame_tick_d;

    logic               tick_c;
    logic               enter0_c;
    logic               blank_c;
    logic [DIGIT_W-1:0] sel_digit_c;
    logic [SEG_W-1:0]   dec_seg_c;
    snapshot_t          live_c;

    assign tick_c = (cnt_q == CNT_LAST);

    // Prescaler: 0..REFRESH_DIV-1, wrapping on tick
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick_c) begin
            cnt_d = '0;
        end
    end

    // Slot sequencer; the first tick after reset enters SLOT0 instead of advancing
    always_comb begin
        slot_d = slot_q;
        run_d  = run_q;
        if (tick_c) begin
            run_d  = 1'b1;
            slot_d = run_q ? slot_next(slot_q) : SLOT0;
        end
    end

    assign enter0_c = tick_c && (slot_d == SLOT0);

    // Snapshot capture on frame entry; shadow_d is also the view used for this update
    always_comb begin
        live_c   = '{d1: digit1, d2: digit2, d3: digit3, d4: digit4, blank_lz: blank_lz};
        shadow_d = shadow_q;
        if (enter0_c) begin
            shadow_d = live_c;
        end
    end

    // Digit select and leading-zero suppression for the slot being entered
    always_comb begin
        sel_digit_c = shadow_d.d4;
        blank_c     = 1'b0;
        case (slot_d)
            SLOT0: begin
                sel_digit_c = shadow_d.d1;
                blank_c     = shadow_d.blank_lz && (shadow_d.d1 == 4'd0);
            end
            SLOT1: begin
                sel_digit_c = shadow_d.d2;
                blank_c     = shadow_d.blank_lz && (shadow_d.d1 == 4'd0)
                              && (shadow_d.d2 == 4'd0);
            end
            SLOT2: begin
                sel_digit_c = shadow_d.d3;
                blank_c     = shadow_d.blank_lz && (shadow_d.d1 == 4'd0)
                              && (shadow_d.d2 == 4'd0) && (shadow_d.d3 == 4'd0);
            end
            SLOT3: begin
                sel_digit_c = shadow_d.d4;
                blank_c     = 1'b0;
            end
        endcase
    end

    seg7_decoder u_dec (
        .digit (sel_digit_c),
        .seg_c (dec_seg_c)
    );

    // Output update only on tick; frame_tick marks the SLOT0 update
    always_comb begin
        an_d         = an_q;
        seg_d        = seg_q;
        frame_tick_d = 1'b0;
        if (tick_c) begin
            frame_tick_d = enter0_c;
            if (blank_c) begin
                an_d  = AN_OFF;
                seg_d = SEG_BLANK;
            end else begin
                an_d  = slot_anode(slot_d);
                seg_d = dec_seg_c;
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            slot_q       <= SLOT0;
            run_q        <= 1'b0;
            shadow_q     <= '0;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            run_q        <= run_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: reference model feeding a scoreboard, plus directed checks.
module tb_seg_scan_controller;

    localparam int unsigned DIV = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       ft;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] digit1, digit2, digit3, digit4;
    logic       blank_lz;
    logic [3:0] an, an1;
    logic [6:0] seg, seg1;
    logic       frame_tick, frame_tick1;

    int n_checks = 0;
    int n_errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state (DIV = 4 instance)
    int         m_cnt;
    int         m_slot;
    bit         m_run;
    logic [3:0] m_d[4];
    bit         m_bl;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    bit         m_ft;
    int         k1;

    seg_scan_controller #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
        .blank_lz(blank_lz),
        .an(an), .seg(seg), .frame_tick(frame_tick)
    );

    seg_scan_controller #(.REFRESH_DIV(1), .CNT_W(1)) dut1 (
        .clk(clk), .rst(rst),
        .digit1(4'd1), .digit2(4'd2), .digit3(4'd3), .digit4(4'd4),
        .blank_lz(1'b0),
        .an(an1), .seg(seg1), .frame_tick(frame_tick1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_pat(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Reference model: predicts outputs after each rising edge
    initial begin
        bit blank;
        m_cnt = 0; m_slot = 0; m_run = 0; m_bl = 0;
        m_an = 4'hF; m_seg = 7'h7F; m_ft = 0;
        for (int j = 0; j < 4; j++) m_d[j] = 4'd0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cnt = 0; m_slot = 0; m_run = 0; m_bl = 0;
                for (int j = 0; j < 4; j++) m_d[j] = 4'd0;
                m_an = 4'hF; m_seg = 7'h7F; m_ft = 0;
            end else begin
                m_ft = 0;
                if (m_cnt == int'(DIV) - 1) begin
                    m_cnt  = 0;
                    m_slot = m_run ? (m_slot + 1) % 4 : 0;
                    m_run  = 1;
                    if (m_slot == 0) begin
                        m_d[0] = digit1; m_d[1] = digit2;
                        m_d[2] = digit3; m_d[3] = digit4;
                        m_bl   = blank_lz;
                        m_ft   = 1;
                    end
                    blank = m_bl && (m_slot < 3);
                    for (int j = 0; j <= m_slot; j++) begin
                        if (m_d[j] != 4'd0) blank = 0;
                    end
                    if (blank) begin
                        m_an = 4'hF; m_seg = 7'h7F;
                    end else begin
                        m_an  = 4'hF ^ 4'(4'b1000 >> m_slot);
                        m_seg = ref_pat(m_d[m_slot]);
                    end
                end else begin
                    m_cnt++;
                end
            end
            q0.push_back('{an: m_an, seg: m_seg, ft: m_ft});
        end
    end

    // Reference for the divide-by-1 build: one slot per cycle, fixed digits 1,2,3,4
    initial begin
        int s;
        k1 = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                k1 = 0;
                q1.push_back('{an: 4'hF, seg: 7'h7F, ft: 1'b0});
            end else begin
                s = k1 % 4;
                q1.push_back('{an: 4'hF ^ 4'(4'b1000 >> s), seg: ref_pat(4'(s + 1)), ft: (s == 0)});
                k1++;
            end
        end
    end

    // Scoreboard: compare DUT outputs against predictions away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("sb_an",  32'(an),         32'(e.an));
                check("sb_seg", 32'(seg),        32'(e.seg));
                check("sb_ft",  32'(frame_tick), 32'(e.ft));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("div1_an",  32'(an1),         32'(e.an));
                check("div1_seg", 32'(seg1),        32'(e.seg));
                check("div1_ft",  32'(frame_tick1), 32'(e.ft));
            end
        end
    end

    task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d, input logic bl);
        digit1 = a; digit2 = b; digit3 = c; digit4 = d; blank_lz = bl;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ef);
        check({tag, "_an"},  32'(an),         32'(ea));
        check({tag, "_seg"}, 32'(seg),        32'(es));
        check({tag, "_ft"},  32'(frame_tick), 32'(ef));
    endtask

    // Directed stimulus
    initial begin
        int i;
        rst = 1'b1;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        repeat (3) @(negedge clk);
        chk_out("reset", 4'hF, 7'h7F, 1'b0);
        rst = 1'b0;

        // Dark until the first tick, then a coherent frame
        repeat (3) @(posedge clk);
        #1 chk_out("dark", 4'hF, 7'h7F, 1'b0);
        @(posedge clk);
        #1 chk_out("slot0_1", 4'b0111, 7'b1111001, 1'b1);
        repeat (4) @(posedge clk);
        #1 chk_out("slot1_2", 4'b1011, 7'b0100100, 1'b0);
        set_digits(4'd9, 4'd8, 4'd7, 4'd6, 1'b0);
        repeat (4) @(posedge clk);
        #1 chk_out("slot2_3", 4'b1101, 7'b0110000, 1'b0);
        repeat (4) @(posedge clk);
        #1 chk_out("slot3_4", 4'b1110, 7'b0011001, 1'b0);
        repeat (4) @(posedge clk);
        #1 chk_out("slot0_9", 4'b0111, 7'b0010000, 1'b1);

        // Leading-zero suppression patterns and invalid digit
        @(negedge clk);
        set_digits(4'd0, 4'd0, 4'd0, 4'd7, 1'b1);
        repeat (40) @(negedge clk);
        set_digits(4'd0, 4'd5, 4'd0, 4'd0, 1'b1);
        repeat (40) @(negedge clk);
        set_digits(4'd0, 4'hC, 4'd0, 4'd0, 1'b1);
        repeat (40) @(negedge clk);
        set_digits(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        repeat (40) @(negedge clk);

        // Reset during SLOT2
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        i = 0;
        while (!(m_run && m_slot == 2) && i < 64) begin
            @(negedge clk);
            i++;
        end
        check("slot2_wait", 32'(i < 64), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 chk_out("midrst", 4'hF, 7'h7F, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_out("postrst_dark", 4'hF, 7'h7F, 1'b0);
        @(posedge clk);
        #1 chk_out("restart", 4'b0111, 7'b1111001, 1'b1);

        // Random digit and blanking changes at arbitrary times
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                           1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 3) == 0) begin
                if (digit1 > 4'd9) digit1 = 4'd0;
                if ($urandom_range(0, 1) == 0) digit2 = 4'd0;
            end
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(q0.size() <= 1), 32'd1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
